ast_mux: RTL and testbench



---
 rtl/ast_mux.sv | 165 ++++++++++++++++
 tb/tb_ast_mux.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_mux.sv
// Avalon-ST packet multiplexer: merges RX_DIR input streams into one output stream
// using packet-atomic round-robin arbitration and a single registered output stage.
module ast_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR],
    input  logic                     ast_startofpacket_i [RX_DIR],
    input  logic                     ast_endofpacket_i   [RX_DIR],
    input  logic                     ast_valid_i         [RX_DIR],
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR],
    output logic                     ast_ready_o         [RX_DIR],
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0] dir_o,
    input  logic                     ast_ready_i
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [DIR_SEL_WIDTH-1:0] gnt_reg, gnt_next;
    logic [DIR_SEL_WIDTH-1:0] last_reg, last_next;

    logic [DATA_WIDTH-1:0]    data_reg;
    logic                     sop_reg, eop_reg, valid_reg;
    logic [EMPTY_WIDTH-1:0]   empty_reg;
    logic [CHANNEL_WIDTH-1:0] channel_reg;
    logic [DIR_SEL_WIDTH-1:0] dir_reg;

    logic                     sel_valid, sel_sop, sel_eop;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [EMPTY_WIDTH-1:0]   sel_empty;
    logic [CHANNEL_WIDTH-1:0] sel_channel;

    logic                     any_valid;
    logic [DIR_SEL_WIDTH-1:0] rr_pick;
    logic                     out_free;
    logic                     beat_acc;
    logic [RX_DIR-1:0]        ready_vec;

    // View of the currently granted input
    always_comb begin
        sel_valid   = 1'b0;
        sel_sop     = 1'b0;
        sel_eop     = 1'b0;
        sel_data    = '0;
        sel_empty   = '0;
        sel_channel = '0;
        for (int i = 0; i < RX_DIR; i++) begin
            if (int'(gnt_reg) == i) begin
                sel_valid   = ast_valid_i[i];
                sel_sop     = ast_startofpacket_i[i];
                sel_eop     = ast_endofpacket_i[i];
                sel_data    = ast_data_i[i];
                sel_empty   = ast_empty_i[i];
                sel_channel = ast_channel_i[i];
            end
        end
    end

    // Round-robin search last+1, last+2, ...; scanning the distance downwards
    // lets the closest valid input overwrite any farther candidate.
    always_comb begin
        any_valid = 1'b0;
        rr_pick   = '0;
        for (int k = RX_DIR; k >= 1; k--) begin
            for (int j = 0; j < RX_DIR; j++) begin
                if (ast_valid_i[j] && (j == (int'(last_reg) + k) % RX_DIR)) begin
                    any_valid = 1'b1;
                    rr_pick   = DIR_SEL_WIDTH'(j);
                end
            end
        end
    end

    assign out_free = !valid_reg || ast_ready_i;
    assign beat_acc = (state_reg == LOCKED) && sel_valid && out_free;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            last_reg  <= DIR_SEL_WIDTH'(RX_DIR - 1);
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    state_next = LOCKED;
                    gnt_next   = rr_pick;
                end
            end
            LOCKED: begin
                if (beat_acc && sel_eop) begin
                    state_next = IDLE;
                    last_next  = gnt_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready follows downstream ready combinationally, only for the granted input
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RX_DIR; i++) begin
            ready_vec[i] = (state_reg == LOCKED) && (int'(gnt_reg) == i) && out_free;
        end
    end

    for (genvar gi = 0; gi < RX_DIR; gi++) begin : g_ready
        assign ast_ready_o[gi] = ready_vec[gi];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_reg    <= '0;
            sop_reg     <= 1'b0;
            eop_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            empty_reg   <= '0;
            channel_reg <= '0;
            dir_reg     <= '0;
        end else if (beat_acc) begin
            data_reg    <= sel_data;
            sop_reg     <= sel_sop;
            eop_reg     <= sel_eop;
            valid_reg   <= 1'b1;
            empty_reg   <= sel_empty;
            channel_reg <= sel_channel;
            dir_reg     <= gnt_reg;
        end else if (ast_ready_i) begin
            valid_reg   <= 1'b0;
        end
    end

    assign ast_data_o          = data_reg;
    assign ast_startofpacket_o = sop_reg;
    assign ast_endofpacket_o   = eop_reg;
    assign ast_valid_o         = valid_reg;
    assign ast_empty_o         = empty_reg;
    assign ast_channel_o       = channel_reg;
    assign dir_o               = dir_reg;

endmodule

// File: tb/tb_ast_mux.sv
// Bench for ast_mux: per-input scoreboard model plus directed arbitration, latency,
// reset and single-input scenarios.
module tb_ast_mux;
    localparam int DW = 64, CW = 8, EW = 3, N = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [EW-1:0] e;
        logic [CW-1:0] c;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [DW-1:0] data_i  [N];
    logic          sop_i   [N];
    logic          eop_i   [N];
    logic          valid_i [N];
    logic [EW-1:0] empty_i [N];
    logic [CW-1:0] chan_i  [N];
    logic          ready_o [N];
    logic [DW-1:0] data_o;
    logic          sop_o, eop_o, valid_o, ready_i;
    logic [EW-1:0] empty_o;
    logic [CW-1:0] chan_o;
    logic [1:0]    dir_o;

    logic [DW-1:0] data1_i  [1];
    logic          sop1_i   [1];
    logic          eop1_i   [1];
    logic          valid1_i [1];
    logic [EW-1:0] empty1_i [1];
    logic [CW-1:0] chan1_i  [1];
    logic          ready1_o [1];
    logic [DW-1:0] data1_o;
    logic          sop1_o, eop1_o, valid1_o, ready1_i;
    logic [EW-1:0] empty1_o;
    logic [CW-1:0] chan1_o;
    logic          dir1_o;

    ast_mux #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .RX_DIR(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ast_data_i(data_i), .ast_startofpacket_i(sop_i), .ast_endofpacket_i(eop_i),
        .ast_valid_i(valid_i), .ast_empty_i(empty_i), .ast_channel_i(chan_i),
        .ast_ready_o(ready_o),
        .ast_data_o(data_o), .ast_startofpacket_o(sop_o), .ast_endofpacket_o(eop_o),
        .ast_valid_o(valid_o), .ast_empty_o(empty_o), .ast_channel_o(chan_o),
        .dir_o(dir_o), .ast_ready_i(ready_i)
    );

    ast_mux #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .RX_DIR(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .ast_data_i(data1_i), .ast_startofpacket_i(sop1_i), .ast_endofpacket_i(eop1_i),
        .ast_valid_i(valid1_i), .ast_empty_i(empty1_i), .ast_channel_i(chan1_i),
        .ast_ready_o(ready1_o),
        .ast_data_o(data1_o), .ast_startofpacket_o(sop1_o), .ast_endofpacket_o(eop1_o),
        .ast_valid_o(valid1_o), .ast_empty_o(empty1_o), .ast_channel_o(chan1_o),
        .dir_o(dir1_o), .ast_ready_i(ready1_i)
    );

    // Model: beats waiting to be offered, and beats accepted but not yet seen on the output
    beat_t         src_q [N][$];
    beat_t         exp_q [N][$];
    bit            acc [N];
    bit            hold_prev, in_pkt, rand_ready, rand_en;
    beat_t         prev_out;
    logic [1:0]    prev_dir;
    int            cur_dir, cyc, pkt_start;
    int            out_order[$];
    int            out_start[$];
    int            out_cyc_log[$];
    logic [DW-1:0] out_data_log[$];
    int            checks = 0, errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e,
                                 input logic [EW-1:0] em, input logic [CW-1:0] ch);
        return {d, s, e, em, ch};
    endfunction

    task automatic send_pkt(input int port, input int len, input logic [DW-1:0] base,
                            input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        for (int b = 0; b < len; b++)
            src_q[port].push_back(mk(base + DW'(b), b == 0, b == len - 1,
                                     (b == len - 1) ? emp : '0, ch));
    endtask

    // One clock: settle last edge into the model, drive new inputs, then observe
    task automatic cycle();
        beat_t cur, e;
        int    nrdy;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++)
            if (acc[i]) exp_q[i].push_back(src_q[i].pop_front());
        cur = {data_o, sop_o, eop_o, empty_o, chan_o};
        if (hold_prev)
            check("hold_stable", {valid_o, cur, dir_o}, {1'b1, prev_out, prev_dir});
        ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        for (int i = 0; i < N; i++) begin
            valid_i[i] = (rand_en ? ($urandom_range(0, 3) != 0) : 1'b1) && (src_q[i].size() > 0);
            if (src_q[i].size() > 0) {data_i[i], sop_i[i], eop_i[i], empty_i[i], chan_i[i]} = src_q[i][0];
            else {data_i[i], sop_i[i], eop_i[i], empty_i[i], chan_i[i]} = '0;
        end
        #1;
        nrdy = 0;
        for (int i = 0; i < N; i++) nrdy += int'(ready_o[i]);
        if (valid_o && !ready_i) check("bp_ready_low", nrdy, 0);
        else check("ready_onehot", nrdy <= 1, 1);
        for (int i = 0; i < N; i++) acc[i] = valid_i[i] && ready_o[i];
        if (valid_o && ready_i) begin
            if (exp_q[dir_o].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_beat: dir %0d gave data %0h, expected no beat", dir_o, data_o);
            end else begin
                e = exp_q[dir_o].pop_front();
                check("sb_beat", cur, e);
            end
            if (in_pkt) check("atomic_dir", dir_o, cur_dir);
            else begin
                cur_dir   = int'(dir_o);
                pkt_start = cyc;
                out_order.push_back(int'(dir_o));
                out_start.push_back(cyc);
            end
            out_cyc_log.push_back(cyc);
            out_data_log.push_back(data_o);
            in_pkt = !eop_o;
            if (eop_o) $display("pkt dir=%0d start=%0d end=%0d chan=%0h", dir_o, pkt_start, cyc, chan_o);
        end
        hold_prev = valid_o && !ready_i;
        prev_out  = cur;
        prev_dir  = dir_o;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n++;
            busy = valid_o;
            for (int i = 0; i < N; i++)
                if (src_q[i].size() > 0 || exp_q[i].size() > 0 || acc[i]) busy = 1'b1;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            valid_i[i] = 1'b0;
            acc[i] = 1'b0;
            src_q[i].delete();
            exp_q[i].delete();
        end
        valid1_i[0] = 1'b0;
        hold_prev = 1'b0;
        in_pkt = 1'b0;
        out_order.delete();
        out_start.delete();
        out_cyc_log.delete();
        out_data_log.delete();
        #1;
        check("rst_outputs", {valid_o, sop_o, eop_o, data_o, empty_o, chan_o, dir_o,
                              ready_o[0], ready_o[1], ready_o[2], ready_o[3]}, '0);
        check("rst_outputs_rx1", {valid1_o, sop1_o, eop1_o, data1_o, empty1_o, chan1_o,
                                  dir1_o, ready1_o[0]}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int ord2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int ord4[6] = '{1, 3, 1, 3, 1, 3};
        int offs1[6] = '{0, 1, 3, 4, 6, 7};
        int idx1, nout1, first1;
        bit acc1;

        rand_ready = 1'b0;
        rand_en    = 1'b0;
        ready_i    = 1'b1;
        ready1_i   = 1'b1;
        cyc        = 0;
        for (int i = 0; i < N; i++)
            {data_i[i], sop_i[i], eop_i[i], empty_i[i], chan_i[i]} = '0;
        {data1_i[0], sop1_i[0], eop1_i[0], empty1_i[0], chan1_i[0]} = '0;
        do_reset();

        // Single 3-beat packet on input 0
        send_pkt(0, 3, 64'hD0, 3'd3, 8'd5);
        c0 = cyc + 1;
        run_until_idle("single", 50);
        check("single_beats", out_data_log.size(), 3);
        if (out_data_log.size() == 3) begin
            check("single_d0", out_data_log[0], 64'hD0);
            check("single_d2", out_data_log[2], 64'hD2);
            check("single_lat", out_cyc_log[0], c0 + 2);
            check("single_b2", out_cyc_log[2], c0 + 4);
        end

        // All four inputs busy: strict rotation with one bubble between packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) send_pkt(p, 2, DW'(p * 256 + r * 16), 3'd1, CW'(p));
        run_until_idle("rr4", 200);
        check("rr4_count", out_order.size(), 8);
        for (int k = 0; k < 8 && k < out_order.size(); k++) check("rr4_order", out_order[k], ord2[k]);
        for (int k = 1; k < out_start.size(); k++) check("rr4_gap", out_start[k] - out_start[k-1], 3);

        // Single-beat packets on inputs 1 and 3: wrap past the top index
        do_reset();
        for (int r = 0; r < 3; r++) begin
            send_pkt(1, 1, DW'(64'h1000 + r), 3'd0, 8'h11);
            send_pkt(3, 1, DW'(64'h3000 + r), 3'd2, 8'h33);
        end
        run_until_idle("alt13", 200);
        check("alt13_count", out_order.size(), 6);
        for (int k = 0; k < 6 && k < out_order.size(); k++) check("alt13_order", out_order[k], ord4[k]);
        for (int k = 1; k < out_start.size(); k++) check("alt13_gap", out_start[k] - out_start[k-1], 2);

        // Asynchronous reset mid-packet on input 2, then input 0 must win first
        do_reset();
        send_pkt(2, 6, 64'h2200, 3'd0, 8'h22);
        repeat (4) cycle();
        check("midpkt_active", {valid_o, dir_o}, {1'b1, 2'd2});
        do_reset();
        send_pkt(2, 2, 64'h2300, 3'd0, 8'h22);
        send_pkt(0, 2, 64'h0300, 3'd0, 8'h00);
        run_until_idle("postrst", 100);
        check("postrst_count", out_order.size(), 2);
        if (out_order.size() == 2) begin
            check("postrst_first", out_order[0], 0);
            check("postrst_second", out_order[1], 2);
        end

        // Random mix with 50% downstream ready and gappy sources
        do_reset();
        for (int p = 0; p < 1000; p++)
            send_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), {$urandom, $urandom},
                     EW'($urandom), CW'($urandom));
        rand_ready = 1'b1;
        rand_en    = 1'b1;
        run_until_idle("random", 60000);
        check("random_pkts", out_order.size(), 1000);
        rand_ready = 1'b0;
        rand_en    = 1'b0;
        ready_i    = 1'b1;

        // Single-input build: three 2-beat packets back to back
        idx1 = 0;
        nout1 = 0;
        first1 = -1;
        acc1 = 1'b0;
        for (int c = 0; c < 40 && nout1 < 6; c++) begin
            @(negedge clk);
            if (acc1) idx1++;
            valid1_i[0] = idx1 < 6;
            data1_i[0]  = 64'h100 + DW'(idx1);
            sop1_i[0]   = (idx1 % 2) == 0;
            eop1_i[0]   = (idx1 % 2) == 1;
            empty1_i[0] = '0;
            chan1_i[0]  = 8'h07;
            #1;
            acc1 = valid1_i[0] && ready1_o[0];
            if (valid1_o) begin
                if (first1 < 0) first1 = c;
                check("rx1_data", data1_o, 64'h100 + DW'(nout1));
                check("rx1_dir", dir1_o, 1'b0);
                check("rx1_timing", c - first1, offs1[nout1]);
                $display("rx1 beat %0d data=%0h cyc=%0d", nout1, data1_o, c);
                nout1++;
            end
        end
        valid1_i[0] = 1'b0;
        check("rx1_count", nout1, 6);
        check("rx1_latency", first1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
